// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller.
//   - opcode constants (instr[31:26])
//   - funct constants (instr[5:0]) used by the ALU decoder
//   - 4-bit FSM state encoding
//   - internal aluop selector and 3-bit ALU operation codes
package mips_pkg;

    // Opcodes
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes driven on alucontrol
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Internal selector from the FSM to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [3:0] {
        S_FETCH1  = 4'd0,
        S_FETCH2  = 4'd1,
        S_FETCH3  = 4'd2,
        S_FETCH4  = 4'd3,
        S_DECODE  = 4'd4,
        S_MEMADR  = 4'd5,
        S_LBRD    = 4'd6,
        S_LBWR    = 4'd7,
        S_SBWR    = 4'd8,
        S_RTYPEEX = 4'd9,
        S_RTYPEWR = 4'd10,
        S_BEQEX   = 4'd11,
        S_JEX     = 4'd12,
        S_ADDIEX  = 4'd13,
        S_ADDIWR  = 4'd14
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// ALU control decoder.
//   aluop      in  2  00 add, 01 subtract, 10 decode funct
//   funct      in  6  instr[5:0]
//   alucontrol out 3  ALU operation code
// Unknown funct codes and the unused aluop value fall back to add.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_controller.sv
// Multicycle MIPS controller (Moore FSM) for an 8-bit datapath that
// fetches each 32-bit instruction one byte per cycle.
//   clk        in   1  rising-edge clock
//   reset      in   1  asynchronous, active-low
//   op, funct  in   6  instruction opcode / funct fields
//   zero       in   1  ALU-result-zero flag, used only for BEQ
//   alucontrol out  3  ALU operation
//   alusrca/alusrcb, iord, irwrite, memread, memwrite, memtoreg,
//   pcen, pcsource, regdst, regwrite  out  datapath controls
// While reset is low the state is FETCH1 but the fetch strobes
// (irwrite, memread, pcen) are held off so nothing is written.
module mips_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alucontrol,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       iord,
    output logic [3:0] irwrite,
    output logic       memread,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       pcen,
    output logic [1:0] pcsource,
    output logic       regdst,
    output logic       regwrite
);

    state_t     state;
    state_t     state_next;
    logic [1:0] aluop;
    logic [3:0] irwrite_raw;
    logic       memread_raw;
    logic       pcwrite;
    logic       branch;

    // NOTE: sequential state uses non-blocking assignment so every
    // flop samples its input before any of them updates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH1;
        else        state <= state_next;
    end

    // NOTE: every variable written here gets a default first, so no
    // path through the case statements can infer a latch.
    always_comb begin
        state_next = S_FETCH1;
        case (state)
            S_FETCH1: state_next = S_FETCH2;
            S_FETCH2: state_next = S_FETCH3;
            S_FETCH3: state_next = S_FETCH4;
            S_FETCH4: state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LB, OP_SB: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_RTYPEEX;
                    OP_BEQ:       state_next = S_BEQEX;
                    OP_J:         state_next = S_JEX;
                    OP_ADDI:      state_next = S_ADDIEX;
                    default:      state_next = S_FETCH1;
                endcase
            end
            S_MEMADR:  state_next = (op == OP_LB) ? S_LBRD : S_SBWR;
            S_LBRD:    state_next = S_LBWR;
            S_RTYPEEX: state_next = S_RTYPEWR;
            S_ADDIEX:  state_next = S_ADDIWR;
            default:   state_next = S_FETCH1;
        endcase
    end

    // Moore outputs: a function of state only.
    always_comb begin
        aluop       = ALUOP_ADD;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        iord        = 1'b0;
        irwrite_raw = 4'b0000;
        memread_raw = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        pcsource    = 2'b00;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        pcwrite     = 1'b0;
        branch      = 1'b0;
        case (state)
            S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
                // PC increments by one byte while each byte is latched.
                memread_raw = 1'b1;
                alusrcb     = 2'b01;
                pcwrite     = 1'b1;
                irwrite_raw = 4'b0001 << state[1:0];
            end
            S_DECODE: alusrcb = 2'b11;  // branch target into ALUOut
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_LBRD: begin
                memread_raw = 1'b1;
                iord        = 1'b1;
            end
            S_LBWR: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_SBWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWR: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BEQEX: begin
                alusrca  = 1'b1;
                aluop    = ALUOP_SUB;
                pcsource = 2'b01;
                branch   = 1'b1;
            end
            S_JEX: begin
                pcsource = 2'b10;
                pcwrite  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWR: regwrite = 1'b1;
            default: ;
        endcase
    end

    // Fetch strobes are suppressed combinationally during reset so the
    // forced FETCH1 state cannot load the IR, read memory or move the PC.
    assign irwrite = reset ? irwrite_raw : 4'b0000;
    assign memread = reset & memread_raw;
    assign pcen    = reset & (pcwrite | (branch & zero));

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mips_controller.sv
// Self-checking bench for mips_controller. Expected outputs come from an
// instruction-level model: given the opcode, funct, zero flag and the
// cycle number within the instruction, it returns what every control
// line must be. Literal checks on captured cycles pin the model itself.
module tb_mips_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic [2:0] alucontrol;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic [3:0] irwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       pcen;
    logic [1:0] pcsource;
    logic       regdst;
    logic       regwrite;

    typedef struct packed {
        logic [2:0] alucontrol;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       iord;
        logic [3:0] irwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       pcen;
        logic [1:0] pcsource;
        logic       regdst;
        logic       regwrite;
    } outs_t;

    outs_t act;
    outs_t cap [1:8];
    int    checks = 0;
    int    errors = 0;

    assign act = {alucontrol, alusrca, alusrcb, iord, irwrite, memread,
                  memwrite, memtoreg, pcen, pcsource, regdst, regwrite};

    mips_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .alucontrol (alucontrol),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .iord       (iord),
        .irwrite    (irwrite),
        .memread    (memread),
        .memwrite   (memwrite),
        .memtoreg   (memtoreg),
        .pcen       (pcen),
        .pcsource   (pcsource),
        .regdst     (regdst),
        .regwrite   (regwrite)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    function automatic int latency(input logic [5:0] o);
        case (o)
            6'b100000:                       return 8;  // LB
            6'b101000, 6'b000000, 6'b001000: return 7;  // SB, RTYPE, ADDI
            6'b000100, 6'b000010:            return 6;  // BEQ, J
            default:                         return 5;  // undefined: fetch + decode
        endcase
    endfunction

    function automatic logic [2:0] funct_op(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic outs_t reset_vals();
        outs_t r = '0;
        r.alucontrol = 3'b010;
        r.alusrcb    = 2'b01;
        return r;
    endfunction

    // Control lines for cycle c (1-based) of one instruction.
    function automatic outs_t model(input logic [5:0] o, input logic [5:0] f,
                                    input logic z, input int c);
        outs_t e = '0;
        e.alucontrol = 3'b010;
        if (c <= 4) begin
            e.memread = 1'b1;
            e.irwrite = 4'b0001 << (c - 1);
            e.alusrcb = 2'b01;
            e.pcen    = 1'b1;
        end else if (c == 5) begin
            e.alusrcb = 2'b11;
        end else begin
            case (o)
                6'b100000, 6'b101000: begin  // LB / SB
                    if (c == 6) begin
                        e.alusrca = 1'b1;
                        e.alusrcb = 2'b10;
                    end else if (o == 6'b100000 && c == 7) begin
                        e.memread = 1'b1;
                        e.iord    = 1'b1;
                    end else if (o == 6'b100000) begin
                        e.regwrite = 1'b1;
                        e.memtoreg = 1'b1;
                    end else begin
                        e.memwrite = 1'b1;
                        e.iord     = 1'b1;
                    end
                end
                6'b000000: begin  // RTYPE
                    if (c == 6) begin
                        e.alusrca    = 1'b1;
                        e.alucontrol = funct_op(f);
                    end else begin
                        e.regwrite = 1'b1;
                        e.regdst   = 1'b1;
                    end
                end
                6'b000100: begin  // BEQ
                    e.alusrca    = 1'b1;
                    e.alucontrol = 3'b110;
                    e.pcsource   = 2'b01;
                    e.pcen       = z;
                end
                6'b000010: begin  // J
                    e.pcsource = 2'b10;
                    e.pcen     = 1'b1;
                end
                6'b001000: begin  // ADDI
                    if (c == 6) begin
                        e.alusrca = 1'b1;
                        e.alusrcb = 2'b10;
                    end else begin
                        e.regwrite = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        return e;
    endfunction

    // Runs one instruction from FETCH1, comparing every cycle with the model.
    // If abort_at is nonzero, reset is pulsed low in that cycle after sampling.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int abort_at, input string tag);
        int lat;
        op    = o;
        funct = f;
        zero  = z;
        lat   = latency(o);
        for (int c = 1; c <= 8; c++) cap[c] = '0;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            cap[c] = act;
            check($sformatf("%s_cycle%0d", tag, c), act, model(o, f, z, c));
            if (c == abort_at) begin
                #1 reset = 1'b0;
                #1 check($sformatf("%s_reset_async", tag), act, reset_vals());
                @(posedge clk);
                #1 check($sformatf("%s_reset_held", tag), act, reset_vals());
                #1 reset = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset asserted from time zero, held across an edge.
        #2 check("reset_initial", act, reset_vals());
        @(posedge clk);
        #1 check("reset_over_edge", act, reset_vals());
        #2 reset = 1'b1;

        // RTYPE subtract
        run_instr(6'b000000, 6'b100010, 1'b0, 0, "rtype_sub");
        check("rtype_irw1", cap[1].irwrite, 4'b0001);
        check("rtype_irw2", cap[2].irwrite, 4'b0010);
        check("rtype_irw3", cap[3].irwrite, 4'b0100);
        check("rtype_irw4", cap[4].irwrite, 4'b1000);
        check("rtype_ex_alu", cap[6].alucontrol, 3'b110);
        check("rtype_ex_nowrite", cap[6].regwrite, 1'b0);
        check("rtype_wr_regwrite_regdst", {cap[7].regwrite, cap[7].regdst}, 2'b11);

        // LB
        run_instr(6'b100000, 6'b000000, 1'b1, 0, "lb");
        check("lb_memread_c4", cap[4].memread, 1'b1);
        check("lb_memread_c6", cap[6].memread, 1'b0);
        check("lb_rd_memread_iord", {cap[7].memread, cap[7].iord}, 2'b11);
        check("lb_wr_regwrite_memtoreg", {cap[8].regwrite, cap[8].memtoreg}, 2'b11);

        // BEQ taken / not taken
        run_instr(6'b000100, 6'b000000, 1'b1, 0, "beq_taken");
        check("beq_taken_pcen", cap[6].pcen, 1'b1);
        check("beq_taken_pcsource", cap[6].pcsource, 2'b01);
        run_instr(6'b000100, 6'b000000, 1'b0, 0, "beq_not_taken");
        check("beq_not_taken_pcen", cap[6].pcen, 1'b0);

        // J
        run_instr(6'b000010, 6'b000000, 1'b0, 0, "j");
        check("j_pcen_pcsource", {cap[6].pcen, cap[6].pcsource}, 3'b110);

        // Undefined opcode returns to fetch after decode
        run_instr(6'b111111, 6'b000000, 1'b1, 0, "bad_op");
        check("bad_op_decode_strobes", {cap[5].regwrite, cap[5].memwrite, cap[5].pcen}, 3'b000);

        // SB then ADDI back-to-back
        run_instr(6'b101000, 6'b000000, 1'b0, 0, "sb");
        check("sb_memwrite_c6", cap[6].memwrite, 1'b0);
        check("sb_memwrite_c7", cap[7].memwrite, 1'b1);
        run_instr(6'b001000, 6'b000000, 1'b0, 0, "addi");
        check("addi_wr_regwrite_regdst", {cap[7].regwrite, cap[7].regdst}, 2'b10);
        check("addi_memwrite_c7", cap[7].memwrite, 1'b0);

        // Remaining funct decodes
        run_instr(6'b000000, 6'b100100, 1'b0, 0, "rtype_and");
        check("rtype_and_alu", cap[6].alucontrol, 3'b000);
        run_instr(6'b000000, 6'b100101, 1'b1, 0, "rtype_or");
        check("rtype_or_alu", cap[6].alucontrol, 3'b001);
        run_instr(6'b000000, 6'b101010, 1'b0, 0, "rtype_slt");
        check("rtype_slt_alu", cap[6].alucontrol, 3'b111);
        run_instr(6'b000000, 6'b100000, 1'b0, 0, "rtype_add");
        run_instr(6'b000000, 6'b111000, 1'b0, 0, "rtype_unknown");
        check("rtype_unknown_alu", cap[6].alucontrol, 3'b010);

        // Reset mid-instruction: in DECODE, in LBRD, in RTYPEWR
        run_instr(6'b000000, 6'b100010, 1'b0, 5, "abort_decode");
        run_instr(6'b000000, 6'b100010, 1'b0, 0, "after_abort_decode");
        check("after_abort_irw1", cap[1].irwrite, 4'b0001);
        run_instr(6'b100000, 6'b000000, 1'b0, 7, "abort_lbrd");
        run_instr(6'b000000, 6'b100010, 1'b0, 7, "abort_rtypewr");
        run_instr(6'b000010, 6'b000000, 1'b0, 0, "j_after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
